// File: rtl/fp_add_seq.sv
// Multi-cycle minifloat adder/subtractor: 1 sign, EXP_W exponent, MAN_W mantissa with hidden 1.
// Serial alignment and normalisation, one bit per cycle, behind a start/busy/done handshake.
`timescale 1ns/1ps
module fp_add_seq #(
  parameter int unsigned EXP_W = 3,
  parameter int unsigned MAN_W = 4,
  parameter int unsigned BIAS  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       sub,
  input  logic [EXP_W+MAN_W:0]       op_a,
  input  logic [EXP_W+MAN_W:0]       op_b,
  output logic                       busy,
  output logic                       done,
  output logic [EXP_W+MAN_W:0]       result,
  output logic                       ovf,
  output logic                       unf
);
  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  // The bias never enters the datapath; it only has to be a legal biased exponent.
  if (BIAS == 0 || BIAS > ((1 << EXP_W) - 1)) begin : g_bad_bias
    $error("fp_add_seq: BIAS out of range for EXP_W");
  end

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [SIG_W-1:0]   x_q, x_d, y_q, y_d;
  logic [SIG_W:0]     s_q, s_d;
  logic [EXP_W-1:0]   exp_q, exp_d, cnt_q, cnt_d;
  logic               sign_x_q, sign_x_d, sign_y_q, sign_y_d;
  logic [W-1:0]       result_q, result_d;
  logic               ovf_q, ovf_d, unf_q, unf_d, busy_q, busy_d, done_q, done_d;

  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   ma, mb;
  logic               sa, sb, a_big;

  assign ea    = op_a[MAN_W +: EXP_W];
  assign eb    = op_b[MAN_W +: EXP_W];
  assign ma    = op_a[MAN_W-1:0];
  assign mb    = op_b[MAN_W-1:0];
  assign sa    = op_a[W-1];
  assign sb    = op_b[W-1] ^ sub;
  assign a_big = {ea, ma} >= {eb, mb};

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    s_d      = s_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    sign_x_d = sign_x_q;
    sign_y_d = sign_y_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          unf_d = 1'b0;
          if (ea == '0) begin
            result_d = (eb == '0) ? '0 : {sb, op_b[W-2:0]};
            state_d  = S_DONE;
          end else if (eb == '0) begin
            result_d = op_a;
            state_d  = S_DONE;
          end else begin
            x_d      = a_big ? {1'b1, ma} : {1'b1, mb};
            y_d      = a_big ? {1'b1, mb} : {1'b1, ma};
            sign_x_d = a_big ? sa : sb;
            sign_y_d = a_big ? sb : sa;
            exp_d    = a_big ? ea : eb;
            cnt_d    = a_big ? (ea - eb) : (eb - ea);
            state_d  = (cnt_d != '0) ? S_ALIGN : S_ADD;
          end
        end
      end
      S_ALIGN: begin
        y_d   = y_q >> 1;
        cnt_d = cnt_q - EXP_W'(1);
        if (cnt_q == EXP_W'(1)) state_d = S_ADD;
      end
      S_ADD: begin
        // X is never smaller than Y, so the difference cannot go negative
        s_d     = (sign_x_q == sign_y_q) ? ({1'b0, x_q} + {1'b0, y_q})
                                         : ({1'b0, x_q} - {1'b0, y_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        if (s_q == '0) begin
          result_d = '0;
          state_d  = S_DONE;
        end else if (s_q[SIG_W]) begin
          if (exp_q == EXP_MAX) begin
            result_d = {sign_x_q, {(W-1){1'b1}}};
            ovf_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            s_d   = s_q >> 1;
            exp_d = exp_q + EXP_W'(1);
          end
        end else if (!s_q[SIG_W-1]) begin
          if (exp_q == EXP_W'(1)) begin
            result_d = '0;
            unf_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            s_d   = s_q << 1;
            exp_d = exp_q - EXP_W'(1);
          end
        end else begin
          result_d = {sign_x_q, exp_q, s_q[MAN_W-1:0]};
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      s_q      <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      sign_x_q <= 1'b0;
      sign_y_q <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      s_q      <= s_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      sign_x_q <= sign_x_d;
      sign_y_q <= sign_y_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
endmodule

// File: tb/tb_fp_add_seq.sv
// Self-checking bench for fp_add_seq: directed cases with known answers, then random
// operands checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_fp_add_seq;
  logic       clk = 1'b0;
  logic       rst_n, start, sub;
  logic [7:0] op_a, op_b, result;
  logic       busy, done, ovf, unf;
  int         compared = 0;
  int         mismatched = 0;

  fp_add_seq #(.EXP_W(3), .MAN_W(4), .BIAS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: values as integer significands, alignment truncates, result found from MSB position.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic [7:0] r, output logic o, output logic u, output int lat);
    int ea, eb, ma, mb, sa, sb, ex, mx, sx, ey, my, sy, d, sum, p, ne, man;
    ea = int'(a[6:4]); eb = int'(b[6:4]);
    ma = 16 + int'(a[3:0]); mb = 16 + int'(b[3:0]);
    sa = int'(a[7]); sb = int'(b[7] ^ s);
    o = 1'b0; u = 1'b0;
    if (ea == 0 || eb == 0) begin
      lat = 1;
      if (ea == 0 && eb == 0) r = 8'h00;
      else if (ea == 0)       r = {sb[0], b[6:0]};
      else                    r = a;
      return;
    end
    if (ea * 32 + ma >= eb * 32 + mb) begin
      ex = ea; mx = ma; sx = sa; ey = eb; my = mb; sy = sb;
    end else begin
      ex = eb; mx = mb; sx = sb; ey = ea; my = ma; sy = sa;
    end
    d   = ex - ey;
    sum = (sx == sy) ? mx + (my >> d) : mx - (my >> d);
    if (sum == 0) begin
      r = 8'h00; lat = 3 + d;
      return;
    end
    p = 0;
    for (int i = 0; i < 6; i++) if ((sum >> i) & 1) p = i;
    ne = ex + p - 4;
    if (ne > 7) begin
      r = {sx[0], 7'h7F}; o = 1'b1; lat = 3 + d;
    end else if (ne < 1) begin
      r = 8'h00; u = 1'b1; lat = 3 + d + (ex - 1);
    end else begin
      man = (p >= 4) ? (sum >> (p - 4)) : (sum << (4 - p));
      r   = {sx[0], ne[2:0], man[3:0]};
      lat = 3 + d + ((p >= 4) ? (p - 4) : (4 - p));
    end
  endtask

  // One transaction; with glitch, start is re-pulsed and operands corrupted while busy.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s, input bit glitch,
                        input logic [7:0] er, input logic eo, input logic eu, input int el);
    string t;
    int    lat;
    t = $sformatf("%02h%s%02h", a, s ? "-" : "+", b);
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    check({t, " busy"}, busy, 1);
    if (glitch) begin
      op_a = ~a; op_b = ~b; start = 1'b1;
    end
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (glitch) start = 1'b0;
    end
    check({t, " done_seen"}, done, 1);
    check({t, " latency"}, lat, el);
    check({t, " result"}, result, er);
    check({t, " ovf"}, ovf, eo);
    check({t, " unf"}, unf, eu);
    @(posedge clk); #1;
    check({t, " done_pulse"}, done, 0);
    check({t, " idle"}, busy, 0);
    check({t, " held"}, result, er);
  endtask

  initial begin
    logic [7:0] a, b, er;
    logic       s, eo, eu;
    int         el, extra_done;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = 8'h00; op_b = 8'h00;
    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 8'h00);
    check("reset ovf", ovf, 0);
    check("reset unf", unf, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op(8'h30, 8'h30, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0, 4);
    run_op(8'h30, 8'h10, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0, 5);
    run_op(8'h10, 8'h30, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0, 5);
    run_op(8'h38, 8'h34, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 5);
    run_op(8'h38, 8'hB8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3);
    run_op(8'h18, 8'h14, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3);
    run_op(8'h00, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1);
    run_op(8'h00, 8'h25, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1);
    run_op(8'h30, 8'h10, 1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 5);
    run_op(8'h7F, 8'h7F, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0, 3);

    // Abort during ALIGN: flags and result from the overflow case above must clear at once.
    @(negedge clk);
    op_a = 8'h70; op_b = 8'h10; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 8'h00);
    check("abort ovf", ovf, 0);
    @(negedge clk); rst_n = 1'b1;
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    check("abort no_done", extra_done, 0);
    run_op(8'h70, 8'h10, 1'b0, 1'b0, 8'h70, 1'b0, 1'b0, 9);

    for (int i = 0; i < 150; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      if ($urandom_range(0, 9) == 0) a[6:4] = 3'd0;
      model(a, b, s, er, eo, eu, el);
      run_op(a, b, s, 1'b0, er, eo, eu, el);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fp_add_seq.md
Name: fp_add_seq

Overview:
- Multi-cycle sequencer for the team's 8-bit minifloat add/subtract: 1 sign, 3-bit exponent, 4-bit mantissa with a hidden 1.
- Captures two operands on a start pulse, computes the exponent difference and picks the larger-exponent operand.
- Aligns the smaller significand one bit per cycle, adds or subtracts, then normalises one bit per cycle.
- Sits between a register file and the result bus, with a start/busy/done handshake.

Parameters:
- EXP_W, 3, exponent field width.
- MAN_W, 4, stored mantissa width (hidden bit excluded).
- BIAS, 3, exponent bias.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  1 = compute A-B (sign of B inverted at capture).
- op_a  in  8  operand A {s, e[2:0], m[3:0]}.
- op_b  in  8  operand B, same format.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, in DONE only.
- result  out  8  sum; held stable from DONE until the next accepted start.
- ovf  out  1  overflow flag, valid with result.
- unf  out  1  underflow flag, valid with result.

Behaviour:
- Format:
  - e=0 denotes zero; mantissa is ignored.
  - Otherwise value = (-1)^s * 1.m * 2^(e-BIAS).
  - Truncation only, no rounding.
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=8'h00, ovf=0, unf=0; all internal registers cleared. Reset mid-operation aborts with no done pulse.
- FSM states: IDLE, ALIGN, ADD, NORM, DONE.
- IDLE, start=1 (edge 0):
  - Capture operands; effective sign of B = s_b XOR sub; clear ovf/unf.
  - Either operand zero: result = the other operand (B with its effective sign); both zero gives 8'h00; go to DONE.
  - Otherwise: 5-bit significands {1,m}. Swap so X has the larger magnitude (larger exponent; if exponents are equal, larger mantissa). cnt = eX - eY (0..6). Go to ALIGN if cnt>0, else ADD.
- ALIGN: each cycle Y >>= 1 (zero fill, shifted-out bits dropped), cnt--. When cnt reaches 0, go to ADD.
- ADD (1 cycle):
  - Same effective signs: 6-bit S = X + Y.
  - Different signs: S = X - Y (never negative).
  - Result sign = sign of X. Go to NORM.
- NORM, one action per cycle, in priority order:
  1. S==0: result=8'h00, go to DONE.
  2. S[5]=1: S >>= 1, exp++. If exp would exceed 7: result={sign,3'b111,4'b1111}, ovf=1, go to DONE.
  3. S[4]=0: if exp==1, result=8'h00, unf=1, go to DONE; else S <<= 1, exp--.
  4. Otherwise normalised: result={sign, exp, S[3:0]}, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency: done is high after 3 + diff + n_norm rising edges from the start edge, where n_norm = number of NORM shift cycles. Zero-operand bypass: done after 1 edge.
- start while busy is ignored; operands captured at start are not affected by later input changes.
- Back-to-back: start may be accepted in the first IDLE cycle after DONE.

Test Plan:
- 0x30 + 0x30, sub=0 -> result 0x40, ovf=0, unf=0, done after 4 edges (carry shift, n_norm=1).
- 0x30 + 0x10, sub=0 -> diff=2, result 0x34, done after 5 edges; swapped operands (0x10 + 0x30) give the same result and timing.
- 0x38 - 0x34 (sub=1) -> S=00100, two left shifts, result 0x10, unf=0, done after 5 edges; 0x38 + 0xB8 -> result 0x00, unf=0.
- 0x7F + 0x7F -> result 0x7F, ovf=1; 0x18 - 0x14 -> result 0x00, unf=1.
- 0x00 + 0xA5 -> result 0xA5, done after 1 edge; 0x00 - 0x25 -> result 0xA5.
- Pulse start again and change op_a while busy -> ignored, original result returned. Drop rst_n during ALIGN -> all outputs 0 immediately, IDLE, no done pulse; next start operates normally.
